// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared widths, opcodes, defaults and bundle types for the memory stage.
package mem_stage_pkg;
  localparam int PC_WIDTH = 16;
  localparam int OPCODE_WIDTH = 8;
  localparam int IR_WIDTH = 32;
  localparam int REG_WIDTH = 16;
  localparam int MEM_LATENCY_DEF = 2;
  localparam logic [15:0] LED_ADDR_DEF = 16'h2000;
  localparam logic [OPCODE_WIDTH-1:0] OP_ADD = 8'h01;
  localparam logic [OPCODE_WIDTH-1:0] OP_LDB = 8'h40;
  localparam logic [OPCODE_WIDTH-1:0] OP_LDW = 8'h41;
  localparam logic [OPCODE_WIDTH-1:0] OP_STB = 8'h42;
  localparam logic [OPCODE_WIDTH-1:0] OP_STW = 8'h43;
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;
  typedef struct packed {
    logic [PC_WIDTH-1:0] pc;
    logic [OPCODE_WIDTH-1:0] opcode;
    logic [IR_WIDTH-1:0] ir;
    logic [3:0] dst;
    logic [REG_WIDTH-1:0] dval;
    logic regwen;
    logic valid;
  } wb_bundle_t;
  function automatic logic is_mem_op(input logic [OPCODE_WIDTH-1:0] op);
    return op inside {OP_LDB, OP_LDW, OP_STB, OP_STW};
  endfunction
endpackage

// File: rtl/dmem_bank.sv
// dmem_bank: word array with byte-enable write on the falling edge and combinational read.
module dmem_bank #(
  parameter int WORDS = 1024,
  localparam int AW = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic [1:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [15:0]   wdata,
  output logic [15:0]   rdata
);
  logic [15:0] mem [WORDS];
  always_ff @(negedge clk) begin
    if (we[0]) mem[addr][7:0] <= wdata[7:0];
    if (we[1]) mem[addr][15:8] <= wdata[15:8];
  end
  assign rdata = mem[addr];
endmodule

// File: rtl/mem_stage.sv
// mem_stage: pipeline memory stage with fixed-latency load/store FSM and a memory-mapped LED register.
module mem_stage import mem_stage_pkg::*; #(
  parameter int DMEM_WORDS = 1024,
  parameter int MEM_LATENCY = MEM_LATENCY_DEF,
  parameter logic [15:0] LED_ADDR = LED_ADDR_DEF
) (
  input  logic                    I_CLOCK,
  input  logic                    I_RESET,
  input  logic                    I_LOCK,
  input  logic [PC_WIDTH-1:0]     I_PC,
  input  logic [OPCODE_WIDTH-1:0] I_Opcode,
  input  logic [IR_WIDTH-1:0]     I_IR,
  input  logic [3:0]              I_DestRegIdx,
  input  logic [REG_WIDTH-1:0]    I_DestValue,
  input  logic [REG_WIDTH-1:0]    I_MARValue,
  input  logic [REG_WIDTH-1:0]    I_MDRValue,
  input  logic                    I_RegWEn,
  input  logic                    I_EX_Valid,
  output logic                    O_LOCK,
  output logic [PC_WIDTH-1:0]     O_PC,
  output logic [OPCODE_WIDTH-1:0] O_Opcode,
  output logic [IR_WIDTH-1:0]     O_IR,
  output logic [3:0]              O_DestRegIdx,
  output logic [REG_WIDTH-1:0]    O_DestValue,
  output logic                    O_RegWEn,
  output logic                    O_MEM_Valid,
  output logic [REG_WIDTH-1:0]    O_LEDR,
  output logic                    O_MEMStallSignal
);
  localparam int AW = $clog2(DMEM_WORDS);
  localparam int CW = $clog2(MEM_LATENCY + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(MEM_LATENCY > 1 ? MEM_LATENCY - 2 : 0);
  wb_bundle_t out_q, out_d;
  logic [0:0] state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [REG_WIDTH-1:0] led_q, led_d;
  logic lock_q;
  logic mem_op, store, byte_op, sel, is_led, start, complete, busy_wait;
  logic [1:0] be, we;
  logic [15:0] wdata, rdata, word, load_val;
  assign mem_op = I_EX_Valid & is_mem_op(I_Opcode);
  assign store = (I_Opcode == OP_STB) | (I_Opcode == OP_STW);
  assign byte_op = (I_Opcode == OP_LDB) | (I_Opcode == OP_STB);
  assign sel = I_MARValue[0];
  assign is_led = I_MARValue[15:1] == LED_ADDR[15:1];
  assign busy_wait = (state_q == ST_BUSY) & (cnt_q != '0);
  assign start = !I_LOCK & (state_q == ST_IDLE) & mem_op & (MEM_LATENCY > 1);
  assign complete = !I_LOCK & (((state_q == ST_IDLE) & mem_op & (MEM_LATENCY == 1)) | ((state_q == ST_BUSY) & (cnt_q == '0)));
  assign O_MEMStallSignal = ((state_q == ST_IDLE) & mem_op & (MEM_LATENCY > 1)) | busy_wait;
  assign be = byte_op ? (sel ? 2'b10 : 2'b01) : 2'b11;
  assign wdata = byte_op ? {2{I_MDRValue[7:0]}} : I_MDRValue;
  assign we = (complete & store & !is_led & !I_RESET) ? be : 2'b00;
  assign word = is_led ? led_q : rdata;
  assign load_val = byte_op ? {8'h00, sel ? word[15:8] : word[7:0]} : word;
  dmem_bank #(.WORDS(DMEM_WORDS)) u_bank (
    .clk(I_CLOCK), .we(we), .addr(I_MARValue[AW:1]), .wdata(wdata), .rdata(rdata)
  );
  always_comb begin
    out_d = out_q;
    out_d.valid = 1'b0;
    state_d = state_q;
    cnt_d = cnt_q;
    led_d = led_q;
    if (!I_LOCK) begin
      out_d.pc = I_PC;
      out_d.opcode = I_Opcode;
      out_d.ir = I_IR;
      out_d.dst = I_DestRegIdx;
      out_d.valid = I_EX_Valid & (!mem_op | complete);
      out_d.regwen = I_EX_Valid & I_RegWEn & (complete ? !store : !mem_op);
      out_d.dval = complete ? (store ? out_q.dval : load_val) : (I_EX_Valid & !mem_op) ? I_DestValue : out_q.dval;
      state_d = start ? ST_BUSY : complete ? ST_IDLE : state_q;
      cnt_d = start ? CNT_INIT : busy_wait ? cnt_q - 1'b1 : cnt_q;
      led_d = (complete & store & is_led) ? {be[1] ? wdata[15:8] : led_q[15:8], be[0] ? wdata[7:0] : led_q[7:0]} : led_q;
    end
  end
  // Pipeline convention: every stage register updates on the falling edge.
  always_ff @(negedge I_CLOCK) begin
    if (I_RESET) begin
      out_q <= '0;
      state_q <= ST_IDLE;
      cnt_q <= '0;
      led_q <= '0;
      lock_q <= 1'b0;
    end else begin
      out_q <= out_d;
      state_q <= state_d;
      cnt_q <= cnt_d;
      led_q <= led_d;
      lock_q <= I_LOCK;
    end
  end
  assign O_LOCK = lock_q;
  assign O_PC = out_q.pc;
  assign O_Opcode = out_q.opcode;
  assign O_IR = out_q.ir;
  assign O_DestRegIdx = out_q.dst;
  assign O_DestValue = out_q.dval;
  assign O_RegWEn = out_q.regwen;
  assign O_MEM_Valid = out_q.valid;
  assign O_LEDR = led_q;
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed self-checking bench for mem_stage with the default 2-cycle latency.
module tb_mem_stage;
  import mem_stage_pkg::*;
  logic clk = 1'b1;
  logic rst, lock, regwen, ex_valid;
  logic [15:0] pc, dval, mar, mdr;
  logic [7:0] opcode;
  logic [31:0] ir;
  logic [3:0] dst;
  logic o_lock, o_regwen, o_valid, o_stall;
  logic [15:0] o_pc, o_dval, o_ledr;
  logic [7:0] o_opcode;
  logic [31:0] o_ir;
  logic [3:0] o_dst;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  mem_stage dut (
    .I_CLOCK(clk), .I_RESET(rst), .I_LOCK(lock), .I_PC(pc), .I_Opcode(opcode), .I_IR(ir),
    .I_DestRegIdx(dst), .I_DestValue(dval), .I_MARValue(mar), .I_MDRValue(mdr),
    .I_RegWEn(regwen), .I_EX_Valid(ex_valid), .O_LOCK(o_lock), .O_PC(o_pc), .O_Opcode(o_opcode),
    .O_IR(o_ir), .O_DestRegIdx(o_dst), .O_DestValue(o_dval), .O_RegWEn(o_regwen),
    .O_MEM_Valid(o_valid), .O_LEDR(o_ledr), .O_MEMStallSignal(o_stall)
  );
  task automatic tick();
    @(negedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic drive(input logic [7:0] op, input logic [15:0] a, input logic [15:0] d, input logic we);
    ex_valid = 1'b1;
    opcode = op;
    mar = a;
    mdr = d;
    regwen = we;
    pc = pc + 16'd2;
  endtask
  task automatic mem_op(input string tag, input logic [7:0] op, input logic [15:0] a, input logic [15:0] d, input logic we);
    drive(op, a, d, we);
    #1;
    chk({tag, "_stall_idle"}, o_stall, 1);
    tick();
    chk({tag, "_busy_valid"}, o_valid, 0);
    chk({tag, "_busy_stall"}, o_stall, 0);
    tick();
    chk({tag, "_done_valid"}, o_valid, 1);
  endtask
  initial begin
    rst = 1'b1; lock = 1'b0; regwen = 1'b0; ex_valid = 1'b0;
    pc = 16'h0100; dval = '0; mar = '0; mdr = '0; opcode = OP_ADD; ir = 32'h0000_0000; dst = 4'd0;
    tick();
    tick();
    chk("rst_valid", o_valid, 0);
    chk("rst_dval", o_dval, 0);
    chk("rst_ledr", o_ledr, 0);
    chk("rst_regwen", o_regwen, 0);
    chk("rst_stall", o_stall, 0);
    rst = 1'b0;
    drive(OP_ADD, 16'h0000, 16'h0000, 1'b1);
    dval = 16'h1234; dst = 4'd3; ir = 32'hA5A5_0003;
    #1;
    chk("add_stall", o_stall, 0);
    tick();
    chk("add_valid", o_valid, 1);
    chk("add_dval", o_dval, 16'h1234);
    chk("add_regwen", o_regwen, 1);
    chk("add_dst", o_dst, 4'd3);
    chk("add_opcode", o_opcode, OP_ADD);
    chk("add_ir", o_ir, 32'hA5A5_0003);
    chk("add_stall_after", o_stall, 0);
    mem_op("stw10", OP_STW, 16'h0010, 16'hBEEF, 1'b1);
    chk("stw10_regwen", o_regwen, 0);
    mem_op("ldw10", OP_LDW, 16'h0010, 16'h0000, 1'b1);
    chk("ldw10_dval", o_dval, 16'hBEEF);
    chk("ldw10_regwen", o_regwen, 1);
    mem_op("stb11", OP_STB, 16'h0011, 16'h00AA, 1'b0);
    mem_op("ldw10b", OP_LDW, 16'h0010, 16'h0000, 1'b1);
    chk("ldw10b_dval", o_dval, 16'hAAEF);
    mem_op("ldb11", OP_LDB, 16'h0011, 16'h0000, 1'b1);
    chk("ldb11_dval", o_dval, 16'h00AA);
    mem_op("ldb10", OP_LDB, 16'h0010, 16'h0000, 1'b1);
    chk("ldb10_dval", o_dval, 16'h00EF);
    mem_op("stw0", OP_STW, 16'h0000, 16'h1111, 1'b0);
    mem_op("stwled", OP_STW, 16'h2000, 16'h00F0, 1'b0);
    chk("stwled_ledr", o_ledr, 16'h00F0);
    mem_op("ldw0", OP_LDW, 16'h0000, 16'h0000, 1'b1);
    chk("ldw0_dval", o_dval, 16'h1111);
    mem_op("stbled", OP_STB, 16'h2001, 16'h0055, 1'b0);
    chk("stbled_ledr", o_ledr, 16'h55F0);
    mem_op("ldwled", OP_LDW, 16'h2000, 16'h0000, 1'b1);
    chk("ldwled_dval", o_dval, 16'h55F0);
    mem_op("stw20", OP_STW, 16'h0020, 16'h7777, 1'b0);
    drive(OP_STW, 16'h0020, 16'hDEAD, 1'b0);
    tick();
    chk("abort_busy_valid", o_valid, 0);
    rst = 1'b1;
    tick();
    chk("abort_valid", o_valid, 0);
    chk("abort_dval", o_dval, 0);
    chk("abort_ledr", o_ledr, 0);
    chk("abort_lock", o_lock, 0);
    chk("abort_idle_stall", o_stall, 1);
    rst = 1'b0;
    ex_valid = 1'b0;
    tick();
    mem_op("ldw20", OP_LDW, 16'h0020, 16'h0000, 1'b1);
    chk("ldw20_dval", o_dval, 16'h7777);
    drive(OP_STW, 16'h0030, 16'hCAFE, 1'b0);
    tick();
    chk("lock_busy_valid", o_valid, 0);
    lock = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("lock_valid", o_valid, 0);
      chk("lock_olock", o_lock, 1);
    end
    lock = 1'b0;
    tick();
    chk("unlock_valid", o_valid, 1);
    chk("unlock_olock", o_lock, 0);
    chk("unlock_regwen", o_regwen, 0);
    mem_op("ldw30", OP_LDW, 16'h0030, 16'h0000, 1'b1);
    chk("ldw30_dval", o_dval, 16'hCAFE);
    ex_valid = 1'b0;
    regwen = 1'b1;
    tick();
    chk("idle_valid", o_valid, 0);
    chk("idle_regwen", o_regwen, 0);
    drive(OP_ADD, 16'h0000, 16'h0000, 1'b0);
    dval = 16'h0F0F;
    tick();
    chk("add2_valid", o_valid, 1);
    chk("add2_dval", o_dval, 16'h0F0F);
    chk("add2_regwen", o_regwen, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Pipeline memory stage, directly downstream of the execute stage and upstream of writeback.
- Consumes the execute-stage result bundle and performs LDB/LDW/STB/STW against a private word-organised data memory.
- Has a fixed-latency access FSM that stalls upstream during multi-cycle accesses, plus one memory-mapped LED register.
- Non-memory ops pass through to writeback with 1-cycle latency.

Parameters:
- DMEM_WORDS, 1024, data memory depth in 16-bit words (power of 2)
- MEM_LATENCY, 2, cycles a load/store occupies the stage (>=1)
- LED_ADDR, 16'h2000, byte address of the memory-mapped LED register

Ports:
- I_CLOCK  in  1  clock; all state updates on falling edge (pipeline convention)
- I_RESET  in  1  synchronous active-high reset, sampled on falling edge of I_CLOCK
- I_LOCK  in  1  pipeline lock; 1 = stage frozen
- I_PC  in  `PC_WIDTH  PC of instruction
- I_Opcode  in  `OPCODE_WIDTH  opcode
- I_IR  in  `IR_WIDTH  instruction word
- I_DestRegIdx  in  4  scalar destination index
- I_DestValue  in  `REG_WIDTH  ALU result
- I_MARValue  in  `REG_WIDTH  byte address for load/store
- I_MDRValue  in  `REG_WIDTH  store data
- I_RegWEn  in  1  scalar register write enable
- I_EX_Valid  in  1  input bundle valid
- O_LOCK  out  1  registered I_LOCK
- O_PC, O_Opcode, O_IR, O_DestRegIdx  out  as inputs  registered copies
- O_DestValue  out  `REG_WIDTH  load data or pass-through ALU result
- O_RegWEn  out  1  registered write enable to WB
- O_MEM_Valid  out  1  output bundle valid
- O_LEDR  out  `REG_WIDTH  LED register
- O_MEMStallSignal  out  1  combinational stall to execute/decode/fetch

Behaviour:
- Reset (I_RESET=1 at falling edge): all registered outputs 0, FSM=IDLE, counter=0, O_LEDR=0.
  - Memory array is not reset.
  - Reset mid-access aborts it; a pending store is not written.
- I_LOCK=1: FSM, counter and memory hold; O_MEM_Valid<=0; O_LOCK<=1.
- Memory op = I_EX_Valid & opcode in {LDB, LDW, STB, STW}.
- Address decode:
  - word index = I_MARValue[log2(DMEM_WORDS):1]; upper bits ignored (wrap-around).
  - byte select = I_MARValue[0] (0 = low byte).
  - LDW/STW ignore bit 0.
- FSM states IDLE, BUSY.
  - IDLE, memory op, MEM_LATENCY=1: access completes this edge; no stall.
  - IDLE, memory op, MEM_LATENCY>1: go to BUSY with counter=MEM_LATENCY-2; O_MEM_Valid<=0.
  - BUSY with counter!=0: counter decrements; O_MEM_Valid<=0.
  - BUSY with counter==0: complete access; go to IDLE.
- O_MEMStallSignal = (IDLE & memory op & MEM_LATENCY>1) | (BUSY & counter!=0).
  - Upstream holds its bundle stable while stall=1.
  - Resulting latency: MEM_LATENCY edges from acceptance to O_MEM_Valid=1.
- Completion edge behaviour:
  - Stores: STW writes the full word; STB writes only the selected byte of the word.
  - Stores to LED_ADDR (STW, or STB with either byte) update O_LEDR instead of memory, with the same byte rules.
  - LDW: O_DestValue<=word. LDB: O_DestValue<={8'h00, byte} (zero-extended).
  - Loads from LED_ADDR return O_LEDR.
  - Loads: O_RegWEn<=I_RegWEn. Stores: O_RegWEn<=0.
  - O_MEM_Valid<=1.
- Non-memory valid op: 1-cycle pass-through of I_DestValue/I_RegWEn; O_MEM_Valid<=1.
- I_EX_Valid=0: O_MEM_Valid<=0, O_RegWEn<=0.
- Load following store to same address: returns the stored value (sequential completion guarantees it).

Decomposition:
- Shared package/header (global_def.h): opcode defines, widths, LED_ADDR default, MEM_LATENCY default.
- One sub-module `dmem_bank`: synchronous word array with a byte-enable write port (2 bits) and a combinational read port.

Test Plan:
- Reset, then ADD bundle DestValue=16'h1234, RegWEn=1 -> next edge: O_DestValue=16'h1234, O_MEM_Valid=1, stall never asserted.
- STW MAR=16'h0010 MDR=16'hBEEF, then LDW MAR=16'h0010, MEM_LATENCY=2 -> each op holds stall 1 cycle; load result 16'hBEEF; store has O_RegWEn=0.
- STB MAR=16'h0011 MDR=16'h00AA onto word 16'hBEEF, then LDW -> 16'hAAEF; LDB MAR=16'h0011 -> 16'h00AA.
- STW MAR=LED_ADDR MDR=16'h00F0 -> O_LEDR=16'h00F0, memory word (LED_ADDR wrapped) unchanged.
- Assert I_RESET during BUSY of STW MAR=16'h0020 -> FSM=IDLE, outputs 0, word 0x10 (byte addr 0x20) keeps prior value.
- I_LOCK=1 held 3 cycles mid-BUSY -> counter frozen, O_MEM_Valid=0; access completes after unlock with correct total latency.
